apu_dma_ctrl: RTL

Sequencer for the 2A03 external bus: the sprite (OAM) DMA and the DMC sample DMA. It halts the 6502 core via RDY and then takes over the address, R/W and data values sent to the pad logic. It replaces the CPU's address and R/W with DMA-generated cycles, arbitrates DMC against sprite DMA, and keeps reads on get cycles and writes on put cycles.

---
 rtl/apu_dma_pkg.sv | 26 ++
 rtl/apu_dma_if.sv | 31 +++
 rtl/apu_dma_busmux.sv | 43 ++++
 rtl/apu_dma_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/apu_dma_pkg.sv
// Shared types and constants for the 2A03 sprite/DMC DMA sequencer.
package apu_dma_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] OAMDATA_ADDR = 16'h2004;
  localparam logic [DATA_W-1:0] SPR_LAST_IDX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HALT   = 3'd1,
    ST_DUMMY  = 3'd2,
    ST_ALIGN  = 3'd3,
    ST_SPR_RD = 3'd4,
    ST_SPR_WR = 3'd5,
    ST_DMC_RD = 3'd6
  } dma_state_e;

  // Source address of a sprite byte: page in the high byte, index in the low byte.
  function automatic logic [ADDR_W-1:0] spr_addr(input logic [DATA_W-1:0] page,
                                                 input logic [DATA_W-1:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/apu_dma_if.sv
// Bus bundle between the CPU-side logic and the DMA sequencer.
interface apu_dma_if;
  import apu_dma_pkg::*;

  logic              spr_start;
  logic [DATA_W-1:0] spr_page;
  logic              dmc_req;
  logic [ADDR_W-1:0] dmc_addr;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rw;
  logic [DATA_W-1:0] db_in;
  logic              RDY;
  logic [ADDR_W-1:0] Addr_topad;
  logic              RW_topad;
  logic [DATA_W-1:0] db_out;
  logic              db_oe;
  logic              dmc_ack;
  logic              put;
  logic              spr_busy;

  modport master (
    output spr_start, spr_page, dmc_req, dmc_addr, cpu_addr, cpu_rw, db_in,
    input  RDY, Addr_topad, RW_topad, db_out, db_oe, dmc_ack, put, spr_busy
  );

  modport slave (
    input  spr_start, spr_page, dmc_req, dmc_addr, cpu_addr, cpu_rw, db_in,
    output RDY, Addr_topad, RW_topad, db_out, db_oe, dmc_ack, put, spr_busy
  );

endinterface

// File: rtl/apu_dma_busmux.sv
// Pad address / R/W / bus-drive selection decoded from the sequencer state.
module apu_dma_busmux
  import apu_dma_pkg::*;
(
  input  dma_state_e        state,
  input  logic [DATA_W-1:0] page,
  input  logic [DATA_W-1:0] idx,
  input  logic [ADDR_W-1:0] dmc_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rw,
  output logic [ADDR_W-1:0] addr_c,
  output logic              rw_c,
  output logic              db_oe_c
);

  // Halted states repeat the core's address as a read; DMA states own the bus.
  always_comb begin
    addr_c  = cpu_addr;
    rw_c    = cpu_rw;
    db_oe_c = 1'b0;
    case (state)
      ST_HALT, ST_DUMMY, ST_ALIGN: rw_c = 1'b1;
      ST_DMC_RD: begin
        addr_c = dmc_addr;
        rw_c   = 1'b1;
      end
      ST_SPR_RD: begin
        addr_c = spr_addr(page, idx);
        rw_c   = 1'b1;
      end
      ST_SPR_WR: begin
        addr_c  = OAMDATA_ADDR;
        rw_c    = 1'b0;
        db_oe_c = 1'b1;
      end
      default: begin
        addr_c = cpu_addr;
        rw_c   = cpu_rw;
      end
    endcase
  end

endmodule

// File: rtl/apu_dma_ctrl.sv
// Sprite (OAM) and DMC sample DMA sequencer for the 2A03 external bus.
module apu_dma_ctrl
  import apu_dma_pkg::*;
(
  input  logic     CLK,
  input  logic     n_RES,
  apu_dma_if.slave bus
);

  dma_state_e        state_q;
  dma_state_e        state_d;
  logic              put_q;
  logic              spr_pend_q;
  logic              dmc_block_q;
  logic [DATA_W-1:0] page_q;
  logic [DATA_W-1:0] idx_q;
  logic [DATA_W-1:0] buffer_q;

  logic              spr_accept;
  logic              dmc_want;
  logic              req_any;
  logic [ADDR_W-1:0] addr_c;
  logic              rw_c;
  logic              db_oe_c;

  // A new sprite request is taken only when no sprite transfer is outstanding.
  assign spr_accept = bus.spr_start & ~spr_pend_q;
  // The DMC keeps dmc_req high through its ack cycle; mask it for one cycle after service.
  assign dmc_want   = bus.dmc_req & ~dmc_block_q;
  assign req_any    = spr_pend_q | spr_accept | dmc_want;

  // State register.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: halt only on a core read, keep DMA reads on get cycles and writes on put cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any && bus.cpu_rw) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (dmc_want)        state_d = ST_DUMMY;
        else if (!spr_pend_q) state_d = ST_IDLE;
        else if (!put_q)     state_d = ST_ALIGN;
        else                 state_d = ST_SPR_RD;
      end
      ST_DUMMY: begin
        state_d = put_q ? ST_DMC_RD : ST_ALIGN;
      end
      ST_ALIGN: begin
        if (dmc_want)        state_d = ST_DMC_RD;
        else if (spr_pend_q) state_d = ST_SPR_RD;
        else                 state_d = ST_IDLE;
      end
      ST_SPR_RD: begin
        state_d = ST_SPR_WR;
      end
      ST_SPR_WR: begin
        if (idx_q == SPR_LAST_IDX) state_d = ST_IDLE;
        else if (dmc_want)         state_d = ST_DMC_RD;
        else                       state_d = ST_SPR_RD;
      end
      ST_DMC_RD: begin
        state_d = spr_pend_q ? ST_ALIGN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Cycle parity, sprite bookkeeping and the read-to-write data buffer.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      put_q       <= 1'b0;
      spr_pend_q  <= 1'b0;
      dmc_block_q <= 1'b0;
      page_q      <= '0;
      idx_q       <= '0;
      buffer_q    <= '0;
    end else begin
      put_q       <= ~put_q;
      dmc_block_q <= (state_q == ST_DMC_RD);
      if (spr_accept) begin
        spr_pend_q <= 1'b1;
        page_q     <= bus.spr_page;
        idx_q      <= '0;
      end else if (state_q == ST_SPR_WR) begin
        idx_q <= idx_q + DATA_W'(1);
        if (idx_q == SPR_LAST_IDX) spr_pend_q <= 1'b0;
      end
      if (state_q == ST_SPR_RD) buffer_q <= bus.db_in;
    end
  end

  apu_dma_busmux u_busmux (
    .state    (state_q),
    .page     (page_q),
    .idx      (idx_q),
    .dmc_addr (bus.dmc_addr),
    .cpu_addr (bus.cpu_addr),
    .cpu_rw   (bus.cpu_rw),
    .addr_c   (addr_c),
    .rw_c     (rw_c),
    .db_oe_c  (db_oe_c)
  );

  assign bus.RDY        = (state_q == ST_IDLE);
  assign bus.Addr_topad = addr_c;
  assign bus.RW_topad   = rw_c;
  assign bus.db_out     = buffer_q;
  assign bus.db_oe      = db_oe_c;
  assign bus.dmc_ack    = (state_q == ST_DMC_RD);
  assign bus.put        = put_q;
  assign bus.spr_busy   = spr_pend_q;

endmodule
